e_mdu: RTL

Execute-stage multiply/divide unit that runs beside the E-stage ALU and shares its A/B operand buses, E-stage opcode decode and exception flush. It executes MULT/MULTU/DIV/DIVU as multi-cycle operations and owns the architectural HI/LO registers. It serves MFHI/MFLO reads onto a result bus that the E-stage result mux selects instead of the ALU result. It drives `busy` so the hazard unit can stall dependent multiply/divide instructions in D.

---
 rtl/e_mdu.sv | 139 +++++++++++++
 1 files changed

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: multi-cycle MULT/MULTU/DIV/DIVU, owns HI/LO and serves
// MFHI/MFLO onto the E-stage result bus.
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  E_MDUOp,
  input  logic        start,
  input  logic        Req,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] E_MDUOut
);

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMfhi  = 4'd5;
  localparam logic [3:0] OpMflo  = 4'd6;
  localparam logic [3:0] OpMthi  = 4'd7;
  localparam logic [3:0] OpMtlo  = 4'd8;

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);
  localparam logic [CntW-1:0] MultLoad = CntW'(MULT_CYCLES);
  localparam logic [CntW-1:0] DivLoad  = CntW'(DIV_CYCLES);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic [31:0]     hold_hi_q, hold_hi_d, hold_lo_q, hold_lo_d;
  logic            hold_wr_q, hold_wr_d;

  logic        is_mul, is_div, is_signed, accept, commit, idle;
  logic [63:0] a_ext, b_ext, prod;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

  always_comb begin
    is_mul    = (E_MDUOp == OpMult) || (E_MDUOp == OpMultu);
    is_div    = (E_MDUOp == OpDiv)  || (E_MDUOp == OpDivu);
    is_signed = (E_MDUOp == OpMult) || (E_MDUOp == OpDiv);
    idle      = (cnt_q == '0);
    commit    = (cnt_q == CntW'(1));
    // The commit edge also accepts a new op so back-to-back issue loses no cycle.
    accept    = start && !Req && (idle || commit) && (is_mul || is_div);
  end

  // Low 64 bits of the product of sign/zero-extended operands give both signed and unsigned results.
  always_comb begin
    a_ext = is_signed ? {{32{A[31]}}, A} : {32'd0, A};
    b_ext = is_signed ? {{32{B[31]}}, B} : {32'd0, B};
    prod  = a_ext * b_ext;
  end

  // Divide on magnitudes, then restore signs: quotient truncates toward zero, remainder
  // follows the dividend. 0x80000000 / -1 falls out as LO=0x80000000, HI=0.
  always_comb begin
    a_neg  = is_signed && A[31];
    b_neg  = is_signed && B[31];
    a_mag  = a_neg ? (32'd0 - A) : A;
    b_mag  = b_neg ? (32'd0 - B) : B;
    b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    quot   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem    = a_neg ? (32'd0 - r_mag) : r_mag;
  end

  always_comb begin
    hold_hi_d = hold_hi_q;
    hold_lo_d = hold_lo_q;
    hold_wr_d = hold_wr_q;
    cnt_d     = cnt_q;
    if (!idle) begin
      cnt_d = cnt_q - CntW'(1);
    end
    if (accept) begin
      if (is_mul) begin
        hold_hi_d = prod[63:32];
        hold_lo_d = prod[31:0];
        hold_wr_d = 1'b1;
        cnt_d     = MultLoad;
      end else begin
        hold_hi_d = rem;
        hold_lo_d = quot;
        hold_wr_d = (B != 32'd0);
        cnt_d     = DivLoad;
      end
    end
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (commit && hold_wr_q) begin
      hi_d = hold_hi_q;
      lo_d = hold_lo_q;
    end else if (idle && !Req) begin
      if (E_MDUOp == OpMthi) hi_d = A;
      if (E_MDUOp == OpMtlo) lo_d = A;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      hold_hi_q <= 32'd0;
      hold_lo_q <= 32'd0;
      hold_wr_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      hold_hi_q <= hold_hi_d;
      hold_lo_q <= hold_lo_d;
      hold_wr_q <= hold_wr_d;
    end
  end

  always_comb begin
    busy = !idle;
    HI   = hi_q;
    LO   = lo_q;
    case (E_MDUOp)
      OpMfhi:  E_MDUOut = hi_q;
      OpMflo:  E_MDUOut = lo_q;
      default: E_MDUOut = 32'd0;
    endcase
  end

endmodule
